pc_redirect_ctrl: RTL and testbench

//  Arbitrates control-flow redirects (ID-stage jumps, EX-stage branches, optional trap) into a single

---
 rtl/pc_redirect_ctrl.sv | 152 +++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: merges ID-stage jumps, EX-stage branches and (optionally)
// traps into one registered redirect toward pc_reg. It holds one pending
// redirect while fetch is stalled and emits the IF/ID flush pulses.
// Optional feature macro: PC_REDIRECT_TRAP_EN enables the trap request path.
// Without it the trap ports remain in the port list but are ignored.
module pc_redirect_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int ALIGN_CHK = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_b_flag_i,
   input  logic [ADDR_W-1:0] id_b_target_i,
   input  logic              ex_b_flag_i,
   input  logic [ADDR_W-1:0] ex_b_target_i,
   input  logic              fetch_ready_i,
   input  logic              trap_flag_i,
   input  logic [ADDR_W-1:0] trap_target_i,
   output logic              redir_valid_o,
   output logic [ADDR_W-1:0] redir_target_o,
   output logic              flush_if_o,
   output logic              flush_id_o,
   output logic              misalign_o
);

   typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

   // A larger code means an older instruction, so that request has higher priority.
   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_ID   = 2'd1;
   localparam logic [1:0] SRC_EX   = 2'd2;
   localparam logic [1:0] SRC_TRAP = 2'd3;

   state_t            state_r;
   logic [1:0]        src_r;

   logic              trap_req_s;
   logic [ADDR_W-1:0] trap_tgt_s;
   logic [1:0]        win_src_s;
   logic [ADDR_W-1:0] win_tgt_s;
   logic              cap_s;
   logic [ADDR_W-1:0] cap_tgt_s;
   logic              cap_mis_s;

`ifdef PC_REDIRECT_TRAP_EN
   assign trap_req_s = trap_flag_i;
   assign trap_tgt_s = trap_target_i;
`else
   logic unused_trap_s;
   assign unused_trap_s = ^{trap_flag_i, trap_target_i};
   assign trap_req_s    = 1'b0;
   assign trap_tgt_s    = {ADDR_W{1'b0}};
`endif

   // Select the highest-priority request presented this cycle.
   always_comb begin
      win_src_s = SRC_NONE;
      win_tgt_s = {ADDR_W{1'b0}};
      if (trap_req_s) begin
         win_src_s = SRC_TRAP;
         win_tgt_s = trap_tgt_s;
      end else if (ex_b_flag_i) begin
         win_src_s = SRC_EX;
         win_tgt_s = ex_b_target_i;
      end else if (id_b_flag_i) begin
         win_src_s = SRC_ID;
         win_tgt_s = id_b_target_i;
      end else begin
         win_src_s = SRC_NONE;
         win_tgt_s = {ADDR_W{1'b0}};
      end
   end

   // Decide whether the winner is captured. While a redirect is pending,
   // a request at lower priority comes from a younger wrong-path instruction and is dropped.
   always_comb begin
      cap_s = 1'b0;
      if (win_src_s == SRC_NONE) begin
         cap_s = 1'b0;
      end else if (state_r == ST_IDLE) begin
         cap_s = 1'b1;
      end else if (win_src_s >= src_r) begin
         cap_s = 1'b1;
      end else begin
         cap_s = 1'b0;
      end
   end

   // Apply the alignment policy to the winning target.
   always_comb begin
      cap_tgt_s = win_tgt_s;
      cap_mis_s = 1'b0;
      if (ALIGN_CHK != 0) begin
         cap_tgt_s = {win_tgt_s[ADDR_W-1:2], 2'b00};
         cap_mis_s = |win_tgt_s[1:0];
      end else begin
         cap_tgt_s = win_tgt_s;
         cap_mis_s = 1'b0;
      end
   end

   // Redirect FSM: capture, overwrite and consume, with registered one-cycle flush pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         src_r          <= SRC_NONE;
         redir_valid_o  <= 1'b0;
         redir_target_o <= {ADDR_W{1'b0}};
         flush_if_o     <= 1'b0;
         flush_id_o     <= 1'b0;
         misalign_o     <= 1'b0;
      end else begin
         flush_if_o <= 1'b0;
         flush_id_o <= 1'b0;
         misalign_o <= 1'b0;
         if (cap_s) begin
            // When a capture and a consume fall on the same edge, the capture
            // takes effect and the FSM stays pending with the new target.
            state_r        <= ST_PEND;
            src_r          <= win_src_s;
            redir_valid_o  <= 1'b1;
            redir_target_o <= cap_tgt_s;
            flush_if_o     <= 1'b1;
            flush_id_o     <= (win_src_s != SRC_ID);
            misalign_o     <= cap_mis_s;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r       <= ST_IDLE;
                  redir_valid_o <= 1'b0;
               end
               ST_PEND: begin
                  if (fetch_ready_i) begin
                     state_r       <= ST_IDLE;
                     src_r         <= SRC_NONE;
                     redir_valid_o <= 1'b0;
                  end else begin
                     state_r       <= ST_PEND;
                     redir_valid_o <= 1'b1;
                  end
               end
               default: begin
                  state_r       <= ST_IDLE;
                  src_r         <= SRC_NONE;
                  redir_valid_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed testbench for pc_redirect_ctrl. Each step drives inputs on the
// falling edge and pushes the outputs it expects after the next rising edge.
// It then pops those expectations and compares them 1 ns after that edge.
module tb_pc_redirect_ctrl;

   logic        clk;
   logic        rst;
   logic        id_b_flag_i;
   logic [31:0] id_b_target_i;
   logic        ex_b_flag_i;
   logic [31:0] ex_b_target_i;
   logic        fetch_ready_i;
   logic        trap_flag_i;
   logic [31:0] trap_target_i;
   logic        redir_valid_o;
   logic [31:0] redir_target_o;
   logic        flush_if_o;
   logic        flush_id_o;
   logic        misalign_o;

   int n_assert;
   int n_fail;

   typedef struct {
      logic        v;
      logic [31:0] t;
      logic        fi;
      logic        fid;
      logic        mis;
      string       tag;
   } exp_t;

   exp_t exp_q[$];

   pc_redirect_ctrl #(.ADDR_W(32), .ALIGN_CHK(1)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_b_flag_i    (id_b_flag_i),
      .id_b_target_i  (id_b_target_i),
      .ex_b_flag_i    (ex_b_flag_i),
      .ex_b_target_i  (ex_b_target_i),
      .fetch_ready_i  (fetch_ready_i),
      .trap_flag_i    (trap_flag_i),
      .trap_target_i  (trap_target_i),
      .redir_valid_o  (redir_valid_o),
      .redir_target_o (redir_target_o),
      .flush_if_o     (flush_if_o),
      .flush_id_o     (flush_id_o),
      .misalign_o     (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Compare every output against one expectation; the target is only meaningful while valid.
   task automatic check_outputs(input exp_t e);
      chk({e.tag, ".valid"}, {31'd0, redir_valid_o}, {31'd0, e.v});
      if (e.v) chk({e.tag, ".target"}, redir_target_o, e.t);
      chk({e.tag, ".flush_if"}, {31'd0, flush_if_o}, {31'd0, e.fi});
      chk({e.tag, ".flush_id"}, {31'd0, flush_id_o}, {31'd0, e.fid});
      chk({e.tag, ".misalign"}, {31'd0, misalign_o}, {31'd0, e.mis});
   endtask

   task automatic cyc(input logic idf, input logic [31:0] idt,
                      input logic exf, input logic [31:0] ext,
                      input logic trf, input logic [31:0] trt,
                      input logic fr,
                      input logic ev, input logic [31:0] et,
                      input logic efi, input logic efid, input logic emis,
                      input string tag);
      exp_t e;
      exp_t got;
      @(negedge clk);
      id_b_flag_i   = idf;
      id_b_target_i = idt;
      ex_b_flag_i   = exf;
      ex_b_target_i = ext;
      trap_flag_i   = trf;
      trap_target_i = trt;
      fetch_ready_i = fr;
      e.v = ev; e.t = et; e.fi = efi; e.fid = efid; e.mis = emis; e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check_outputs(got);
   endtask

   initial begin
      exp_t r;
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b0;
      id_b_flag_i = 1'b0; id_b_target_i = 32'd0;
      ex_b_flag_i = 1'b0; ex_b_target_i = 32'd0;
      trap_flag_i = 1'b0; trap_target_i = 32'd0;
      fetch_ready_i = 1'b1;

      // Outputs while reset is held.
      #1;
      r.v = 1'b0; r.t = 32'd0; r.fi = 1'b0; r.fid = 1'b0; r.mis = 1'b0; r.tag = "reset";
      check_outputs(r);
      chk("reset.target0", redir_target_o, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // ID-only request.
      cyc(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, "id_only");
      cyc(1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, "id_clear");

      // ID and EX on the same edge: EX wins.
      cyc(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, "id_ex");
      cyc(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, "id_ex_clear");

      // Hold through a stall; an ID request during the stall is dropped.
      cyc(1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b1, 1'b0, "stall_cap");
      cyc(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, "stall1");
      cyc(1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, "stall_drop");
      cyc(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, "stall3");
      cyc(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, "stall_release");

      // Misaligned EX target is masked and flagged for exactly one cycle.
      cyc(1'b0, 32'h0,   1'b1, 32'h206, 1'b0, 32'h0, 1'b1, 1'b1, 32'h204, 1'b1, 1'b1, 1'b1, "misalign");
      cyc(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, "misalign_clear");

      // Overwrite beats consume, and equal priority overwrites.
      cyc(1'b1, 32'h500, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b1, 1'b0, 1'b0, "ow_id");
      cyc(1'b0, 32'h0,   1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 1'b1, 32'h600, 1'b1, 1'b1, 1'b0, "ow_ex");
      cyc(1'b0, 32'h0,   1'b1, 32'h700, 1'b0, 32'h0, 1'b1, 1'b1, 32'h700, 1'b1, 1'b1, 1'b0, "ow_ex_eq");
      cyc(1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, "ow_clear");

      // Back-to-back ID jumps, then the top-of-memory target.
      cyc(1'b1, 32'h800, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h800, 1'b1, 1'b0, 1'b0, "b2b_1");
      cyc(1'b1, 32'h900, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h900, 1'b1, 1'b0, 1'b0, "b2b_2");
      cyc(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, "top_addr");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "top_clear");

      // Trap arriving while an EX redirect is pending.
      cyc(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, "trap_ex_cap");
`ifdef PC_REDIRECT_TRAP_EN
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b0, "trap_ow");
      cyc(1'b0, 32'h0, 1'b1, 32'h300, 1'b1, 32'hC0, 1'b0, 1'b1, 32'hC0, 1'b1, 1'b1, 1'b0, "trap_eq");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "trap_clear");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, "trap_idle");
`else
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, "trap_ignored");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "trap_clear");
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "trap_idle");
`endif
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "quiet");

      // Reset asserted while a redirect is pending clears the outputs without a clock edge.
      cyc(1'b0, 32'h0, 1'b1, 32'h1234, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b1, 1'b0, "rst_pend_cap");
      @(negedge clk);
      ex_b_flag_i = 1'b0;
      rst = 1'b0;
      #1;
      r.v = 1'b0; r.t = 32'd0; r.fi = 1'b0; r.fid = 1'b0; r.mis = 1'b0; r.tag = "rst_mid";
      check_outputs(r);
      chk("rst_mid.target0", redir_target_o, 32'd0);
      @(posedge clk);
      #1;
      r.tag = "rst_held";
      check_outputs(r);
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "post_rst_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
